test_run_monitor: RTL and testbench

Synthesisable, parametrised end-of-test controller for the simulation harness. It generalises the single-`success` testbench driver into a cycle-accurate block with these features:
- sequences DUT reset;
- tracks NUM_CH independent completion/failure channels;
- enforces a runtime cycle limit and a per-channel forward-progress (stall) watchdog;
- reports a single registered verdict with reason code and offending channel.

It sits between the clock/reset generator and the TestHarness. The top-level driver only needs to watch `finished`.

---
 rtl/test_run_pkg.sv | 32 +++
 rtl/test_run_stall_ctr.sv | 46 ++++
 rtl/test_run_monitor.sv | 147 ++++++++++++++
 tb/tb_test_run_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/test_run_pkg.sv
// Shared types and helpers for the end-of-test run monitor.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package test_run_pkg;

    // Upper bound on channel count handled by lowest_set(); callers zero-extend.
    localparam int MAX_CH = 256;

    typedef enum logic [2:0] {
        R_NONE    = 3'd0,
        R_PASS    = 3'd1,
        R_FAIL    = 3'd2,
        R_TIMEOUT = 3'd3,
        R_STALL   = 3'd4
    } reason_t;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_set(input logic [MAX_CH-1:0] vec);
        lowest_set = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = i;
        end
    endfunction

endpackage

// File: rtl/test_run_stall_ctr.sv
// Per-channel forward-progress watchdog: counts heartbeat-free cycles while enabled.
// Latency: expired asserts the cycle after the count reaches STALL_CYCLES.
// Backpressure: none; heartbeat or done clears the count, disable freezes it.
module test_run_stall_ctr
    import test_run_pkg::*;
#(
    parameter int STALL_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic heartbeat,
    input  logic done,
    output logic expired
);

    generate
        if (STALL_CYCLES == 0) begin : g_disabled
            // Watchdog removed; keep inputs referenced so nothing dangles.
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset, enable, heartbeat, done};
            assign expired       = 1'b0;
        end else begin : g_enabled
            localparam int SW = $clog2(STALL_CYCLES + 1);
            localparam logic [SW-1:0] LIMIT = SW'(STALL_CYCLES);

            logic [SW-1:0] cnt;

            // Count idle RUN cycles, saturating at the limit; progress or done clears.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt <= '0;
                end else if (enable) begin
                    if (heartbeat || done) begin
                        cnt <= '0;
                    end else if (cnt != LIMIT) begin
                        cnt <= cnt + SW'(1);
                    end
                end
            end

            assign expired = (cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/test_run_monitor.sv
// End-of-test controller: sequences DUT reset, tracks channels, issues a sticky verdict.
// Latency: verdict registered one cycle after the qualifying RUN-cycle input.
// Backpressure: none; inputs sampled every cycle, ignored outside RUN.
module test_run_monitor
    import test_run_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 64,
    parameter int RESET_CYCLES = 16,
    parameter int STALL_CYCLES = 1024,
    parameter bit DONE_ALL     = 1'b1,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_fail,
    input  logic [NUM_CH-1:0] ch_heartbeat,
    output logic              dut_reset,
    output logic              running,
    output logic              finished,
    output logic              passed,
    output logic              failed,
    output logic [2:0]        reason,
    output logic [CH_W-1:0]   fail_ch,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [NUM_CH-1:0] done_mask
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    state_t            state_q, state_nxt;
    reason_t           reason_q, reason_nxt;
    logic [CH_W-1:0]   fail_ch_q, fail_ch_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [NUM_CH-1:0] done_mask_q;
    logic [NUM_CH-1:0] eff_done;
    logic [NUM_CH-1:0] stall_exp;
    logic              in_run;
    logic              any_fail, timeout_hit, any_stall, pass_cond;

    assign in_run   = (state_q == S_RUN);
    assign eff_done = done_mask_q | ch_done;

    // One watchdog per channel; done channels are held cleared.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stall
        test_run_stall_ctr #(
            .STALL_CYCLES(STALL_CYCLES)
        ) u_stall (
            .clock    (clock),
            .reset    (reset),
            .enable   (in_run),
            .heartbeat(ch_heartbeat[i]),
            .done     (eff_done[i]),
            .expired  (stall_exp[i])
        );
    end

    assign any_fail    = |ch_fail;
    assign timeout_hit = (max_cycles != '0) && (cycle_cnt_q >= max_cycles);
    assign any_stall   = |stall_exp;
    assign pass_cond   = DONE_ALL ? (&eff_done) : (|eff_done);

    // Next-state and verdict selection; fail beats timeout beats stall beats pass.
    always_comb begin
        state_nxt   = state_q;
        reason_nxt  = reason_q;
        fail_ch_nxt = fail_ch_q;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (any_fail) begin
                    state_nxt   = S_FAIL;
                    reason_nxt  = R_FAIL;
                    fail_ch_nxt = CH_W'(lowest_set(MAX_CH'(ch_fail)));
                end else if (timeout_hit) begin
                    state_nxt  = S_FAIL;
                    reason_nxt = R_TIMEOUT;
                end else if (any_stall) begin
                    state_nxt   = S_FAIL;
                    reason_nxt  = R_STALL;
                    fail_ch_nxt = CH_W'(lowest_set(MAX_CH'(stall_exp)));
                end else if (pass_cond) begin
                    state_nxt  = S_PASS;
                    reason_nxt = R_PASS;
                end
            end
            default: begin
                state_nxt = state_q;
            end
        endcase
    end

    // State, verdict and status flags, all registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_HOLD;
            reason_q  <= R_NONE;
            fail_ch_q <= '0;
            dut_reset <= 1'b1;
            running   <= 1'b0;
            finished  <= 1'b0;
            passed    <= 1'b0;
            failed    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            reason_q  <= reason_nxt;
            fail_ch_q <= fail_ch_nxt;
            dut_reset <= (state_nxt == S_HOLD);
            running   <= (state_nxt == S_RUN);
            finished  <= (state_nxt == S_PASS) || (state_nxt == S_FAIL);
            passed    <= (state_nxt == S_PASS);
            failed    <= (state_nxt == S_FAIL);
        end
    end

    // DUT reset hold counter; only advances while holding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (state_q == S_HOLD && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // RUN cycle counter (saturating) and sticky done flags; frozen once terminal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            done_mask_q <= '0;
        end else if (in_run) begin
            if (cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            done_mask_q <= done_mask_q | ch_done;
        end
    end

    assign reason      = reason_q;
    assign fail_ch     = fail_ch_q;
    assign cycle_count = cycle_cnt_q;
    assign done_mask   = done_mask_q;

endmodule

// File: tb/tb_test_run_monitor.sv
// Directed bench for test_run_monitor: reset sequencing, pass, fail, timeout, stall, async reset.
// Inputs change and outputs are sampled on the falling clock edge.
// Each task checks its own scenario against hand-computed values.
module tb_test_run_monitor;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CNT_W-1:0]  max_cycles = '0;
    logic [NUM_CH-1:0] ch_done = '0;
    logic [NUM_CH-1:0] ch_fail = '0;
    logic [NUM_CH-1:0] ch_heartbeat = '1;
    logic              dut_reset, running, finished, passed, failed;
    logic [2:0]        reason;
    logic [CH_W-1:0]   fail_ch;
    logic [CNT_W-1:0]  cycle_count;
    logic [NUM_CH-1:0] done_mask;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    test_run_monitor #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .RESET_CYCLES(4),
        .STALL_CYCLES(8),
        .DONE_ALL    (1'b1),
        .CH_W        (CH_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .max_cycles  (max_cycles),
        .ch_done     (ch_done),
        .ch_fail     (ch_fail),
        .ch_heartbeat(ch_heartbeat),
        .dut_reset   (dut_reset),
        .running     (running),
        .finished    (finished),
        .passed      (passed),
        .failed      (failed),
        .reason      (reason),
        .fail_ch     (fail_ch),
        .cycle_count (cycle_count),
        .done_mask   (done_mask)
    );

    // Reset, release, and leave the bench at the falling edge of RUN cycle 0.
    task automatic start_run(input logic [CNT_W-1:0] maxc);
        bit ok;
        reset        = 1'b1;
        max_cycles   = maxc;
        ch_done      = '0;
        ch_fail      = '0;
        ch_heartbeat = '1;
        @(negedge clock);
        reset = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (running === 1'b1) ok = 1'b1;
        end
        n_vec++;
        if (!ok) begin
            $display("FAIL start_run: running=%b after 20 cycles, required 1", running);
            n_miss++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({dut_reset, running, finished, passed, failed} !== 5'b10000 || reason !== 3'd0 ||
            fail_ch !== '0 || cycle_count !== '0 || done_mask !== '0) begin
            $display("FAIL reset_values: dr=%b run=%b fin=%b pass=%b fail=%b reason=%0d ch=%0d cc=%0d dm=%h, required 1 0 0 0 0 0 0 0 0",
                     dut_reset, running, finished, passed, failed, reason, fail_ch, cycle_count, done_mask);
            n_miss++;
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            n_vec++;
            if (k < 4 && (dut_reset !== 1'b1 || running !== 1'b0)) begin
                $display("FAIL hold_edge%0d: dut_reset=%b running=%b, required 1 0", k, dut_reset, running);
                n_miss++;
            end else if (k == 4 && (dut_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 0)) begin
                $display("FAIL run_edge4: dut_reset=%b running=%b cc=%0d, required 0 1 0", dut_reset, running, cycle_count);
                n_miss++;
            end
        end
    endtask

    task automatic test_all_done_pass();
        start_run('0);
        for (int c = 0; c <= 40; c++) begin
            ch_done = '0;
            if (c % 10 == 0 && c != 0) ch_done[c/10 - 1] = 1'b1;
            if (c == 40) begin
                n_vec++;
                if (finished !== 1'b0 || done_mask !== 4'h7) begin
                    $display("FAIL pass_pre: fin=%b dm=%h, required 0 7", finished, done_mask);
                    n_miss++;
                end
            end
            @(negedge clock);
        end
        ch_done = '0;
        n_vec++;
        if ({finished, passed, failed, running} !== 4'b1100 || reason !== 3'd1 ||
            cycle_count !== 41 || done_mask !== 4'hF || dut_reset !== 1'b0) begin
            $display("FAIL all_done_pass: fin=%b pass=%b fail=%b run=%b reason=%0d cc=%0d dm=%h, required 1 1 0 0 1 41 f",
                     finished, passed, failed, running, reason, cycle_count, done_mask);
            n_miss++;
        end
    endtask

    task automatic test_fail_priority();
        start_run('0);
        repeat (5) @(negedge clock);
        ch_fail = 4'b0110;
        ch_done = 4'b0001;
        @(negedge clock);
        ch_fail = '0;
        ch_done = '0;
        n_vec++;
        if ({finished, passed, failed} !== 3'b101 || reason !== 3'd2 || fail_ch !== 2'd1 || cycle_count !== 6) begin
            $display("FAIL fail_priority: fin=%b pass=%b fail=%b reason=%0d ch=%0d cc=%0d, required 1 0 1 2 1 6",
                     finished, passed, failed, reason, fail_ch, cycle_count);
            n_miss++;
        end
        ch_done = 4'hF;
        ch_fail = 4'b1000;
        repeat (5) @(negedge clock);
        ch_done = '0;
        ch_fail = '0;
        n_vec++;
        if ({finished, passed, failed, dut_reset} !== 4'b1010 || reason !== 3'd2 ||
            fail_ch !== 2'd1 || cycle_count !== 6) begin
            $display("FAIL fail_sticky: fin=%b pass=%b fail=%b dr=%b reason=%0d ch=%0d cc=%0d, required 1 0 1 0 2 1 6",
                     finished, passed, failed, dut_reset, reason, fail_ch, cycle_count);
            n_miss++;
        end
    endtask

    task automatic test_timeout(input bit late_done);
        start_run(32'd100);
        repeat (100) @(negedge clock);
        n_vec++;
        if (finished !== 1'b0 || cycle_count !== 100) begin
            $display("FAIL timeout_pre%0d: fin=%b cc=%0d, required 0 100", late_done, finished, cycle_count);
            n_miss++;
        end
        if (late_done) ch_done = 4'hF;
        @(negedge clock);
        ch_done = '0;
        n_vec++;
        if ({finished, passed, failed} !== 3'b101 || reason !== 3'd3 || cycle_count !== 101 || fail_ch !== '0) begin
            $display("FAIL timeout%0d: fin=%b pass=%b fail=%b reason=%0d cc=%0d ch=%0d, required 1 0 1 3 101 0",
                     late_done, finished, passed, failed, reason, cycle_count, fail_ch);
            n_miss++;
        end
    endtask

    task automatic test_stall();
        start_run('0);
        ch_heartbeat = 4'b1011;
        repeat (8) @(negedge clock);
        n_vec++;
        if (finished !== 1'b0 || cycle_count !== 8) begin
            $display("FAIL stall_pre: fin=%b cc=%0d, required 0 8", finished, cycle_count);
            n_miss++;
        end
        @(negedge clock);
        n_vec++;
        if ({finished, failed} !== 2'b11 || reason !== 3'd4 || fail_ch !== 2'd2 || cycle_count !== 9) begin
            $display("FAIL stall: fin=%b fail=%b reason=%0d ch=%0d cc=%0d, required 1 1 4 2 9",
                     finished, failed, reason, fail_ch, cycle_count);
            n_miss++;
        end
    endtask

    task automatic test_stall_done();
        start_run('0);
        ch_heartbeat = 4'b1011;
        repeat (3) @(negedge clock);
        ch_done = 4'b0100;
        @(negedge clock);
        ch_done = '0;
        repeat (16) @(negedge clock);
        n_vec++;
        if (finished !== 1'b0 || running !== 1'b1 || done_mask !== 4'b0100 || cycle_count !== 20) begin
            $display("FAIL stall_done: fin=%b run=%b dm=%h cc=%0d, required 0 1 4 20",
                     finished, running, done_mask, cycle_count);
            n_miss++;
        end
    endtask

    task automatic test_async_reset();
        start_run('0);
        repeat (10) @(negedge clock);
        ch_done = 4'b0001;
        @(negedge clock);
        ch_done = '0;
        repeat (39) @(negedge clock);
        n_vec++;
        if (cycle_count !== 50 || done_mask !== 4'b0001) begin
            $display("FAIL async_pre: cc=%0d dm=%h, required 50 1", cycle_count, done_mask);
            n_miss++;
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({dut_reset, running, finished, passed, failed} !== 5'b10000 || reason !== 3'd0 ||
            cycle_count !== '0 || done_mask !== '0 || fail_ch !== '0) begin
            $display("FAIL async_reset: dr=%b run=%b fin=%b cc=%0d dm=%h reason=%0d, required 1 0 0 0 0 0",
                     dut_reset, running, finished, cycle_count, done_mask, reason);
            n_miss++;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if (dut_reset !== 1'b1 || running !== 1'b0) begin
            $display("FAIL rehold: dut_reset=%b running=%b, required 1 0", dut_reset, running);
            n_miss++;
        end
        @(negedge clock);
        n_vec++;
        if (dut_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 0) begin
            $display("FAIL rerun: dut_reset=%b running=%b cc=%0d, required 0 1 0", dut_reset, running, cycle_count);
            n_miss++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_all_done_pass();
        test_fail_priority();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_stall();
        test_stall_done();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
